// File: rtl/code_lock_fsm.sv
// Serial-entry code lock: MSB-first bit shift-in, compare on enter, UNLOCK on match, ALARM lockout after MAX_TRIES misses.
// Latency: registered Moore outputs update on the clock edge that samples the input, which is a 1-cycle latency.
// Backpressure: none. Inputs are ignored where they have no effect. Define ALARM_TIMER_EN to require ALARM_CYCLES in ALARM before clear_alarm.
module code_lock_fsm #(
    parameter int                    CODE_WIDTH   = 8,
    parameter logic [CODE_WIDTH-1:0] CODE         = 8'hA5,
    parameter int                    MAX_TRIES    = 3,
    parameter int                    ALARM_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       bit_valid,
    input  logic       bit_in,
    input  logic       enter,
    input  logic       clear_alarm,
    output logic       unlocked,
    output logic       alarm,
    output logic [1:0] try_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        UNLOCK  = 2'd2,
        ALARM   = 2'd3
    } state_t;

    localparam int                CNT_W    = $clog2(CODE_WIDTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CODE_WIDTH);
    localparam logic [1:0]        MAX_T    = 2'(MAX_TRIES);

    state_t                  cur_st, nxt_st;
    logic [CODE_WIDTH-1:0]   shreg, shreg_nxt;
    logic [CNT_W-1:0]        bit_cnt, cnt_nxt;
    logic [1:0]              try_nxt;
    logic [1:0]              try_inc;
    logic                    match;
    logic                    alarm_exit;

`ifdef ALARM_TIMER_EN
    localparam int               TMR_W   = $clog2(ALARM_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(ALARM_CYCLES);

    logic [TMR_W-1:0] alarm_tmr;

    // Timer is zero outside ALARM, so it is already clear on the entry and exit edges.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            alarm_tmr <= '0;
        end else if (cur_st == ALARM && nxt_st == ALARM) begin
            if (alarm_tmr != TMR_MAX) begin
                alarm_tmr <= alarm_tmr + 1'b1;
            end
        end else begin
            alarm_tmr <= '0;
        end
    end

    assign alarm_exit = clear_alarm && (alarm_tmr == TMR_MAX);
`else
    assign alarm_exit = clear_alarm;
`endif

    assign match   = (bit_cnt == CNT_FULL) && (shreg == CODE);
    assign try_inc = try_count + 2'd1;
    assign state   = cur_st;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cur_st    <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            try_count <= 2'd0;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            cur_st    <= nxt_st;
            shreg     <= shreg_nxt;
            bit_cnt   <= cnt_nxt;
            try_count <= try_nxt;
            unlocked  <= (nxt_st == UNLOCK);
            alarm     <= (nxt_st == ALARM);
        end
    end

    always_comb begin
        nxt_st    = cur_st;
        shreg_nxt = shreg;
        cnt_nxt   = bit_cnt;
        try_nxt   = try_count;
        case (cur_st)
            IDLE, COLLECT: begin
                // enter has priority: a bit arriving with enter is dropped
                if (enter) begin
                    shreg_nxt = '0;
                    cnt_nxt   = '0;
                    if (match) begin
                        nxt_st  = UNLOCK;
                        try_nxt = 2'd0;
                    end else begin
                        try_nxt = try_inc;
                        nxt_st  = (try_inc == MAX_T) ? ALARM : IDLE;
                    end
                end else if (bit_valid) begin
                    nxt_st = COLLECT;
                    if (bit_cnt < CNT_FULL) begin
                        shreg_nxt = {shreg[CODE_WIDTH-2:0], bit_in};
                        cnt_nxt   = bit_cnt + 1'b1;
                    end
                end
            end
            UNLOCK: begin
                if (enter) begin
                    nxt_st = IDLE;
                end
            end
            ALARM: begin
                if (alarm_exit) begin
                    nxt_st  = IDLE;
                    try_nxt = 2'd0;
                end
            end
            default: begin
                nxt_st = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_code_lock_fsm.sv
// Directed bench for code_lock_fsm with CODE=8'hA5, MAX_TRIES=3, ALARM_CYCLES=16.
module tb_code_lock_fsm;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_in = 1'b0;
    logic       enter = 1'b0;
    logic       clear_alarm = 1'b0;
    logic       unlocked;
    logic       alarm;
    logic [1:0] try_count;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    code_lock_fsm dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .enter      (enter),
        .clear_alarm(clear_alarm),
        .unlocked   (unlocked),
        .alarm      (alarm),
        .try_count  (try_count),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [1:0] st, input logic ul,
                            input logic al, input logic [1:0] tc);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".unlocked"}, 32'(unlocked), 32'(ul));
        check({tag, ".alarm"}, 32'(alarm), 32'(al));
        check({tag, ".try_count"}, 32'(try_count), 32'(tc));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [15:0] code, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in    = code[i];
            cyc();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic do_enter();
        enter = 1'b1;
        cyc();
        enter = 1'b0;
    endtask

    // Holds clear_alarm until ALARM is left (bounded) and checks how many edges it took.
    task automatic hold_clear(input string tag, input int exp_n);
        int n;
        n = 0;
        clear_alarm = 1'b1;
        while (state == 2'd3 && n < 40) begin
            cyc();
            n++;
        end
        clear_alarm = 1'b0;
        check(tag, 32'(n), 32'(exp_n));
    endtask

    initial begin
        // Reset
        reset_L = 1'b0;
        repeat (2) cyc();
        check_st("reset", 2'd0, 1'b0, 1'b0, 2'd0);
        reset_L = 1'b1;
        cyc();
        check_st("post_release", 2'd0, 1'b0, 1'b0, 2'd0);

        // Correct code unlocks, UNLOCK ignores bits and clear_alarm, enter re-locks
        send_bits(16'hA5, 8);
        check("t1_collect", 32'(state), 32'd1);
        do_enter();
        check_st("t1_unlock", 2'd2, 1'b1, 1'b0, 2'd0);
        send_bits(16'h0, 3);
        clear_alarm = 1'b1;
        cyc();
        clear_alarm = 1'b0;
        check_st("t1_ignore", 2'd2, 1'b1, 1'b0, 2'd0);
        do_enter();
        check_st("t1_relock", 2'd0, 1'b0, 1'b0, 2'd0);

        // Three wrong codes -> ALARM
        send_bits(16'hA4, 8);
        do_enter();
        check_st("t2_miss1", 2'd0, 1'b0, 1'b0, 2'd1);
        send_bits(16'hA4, 8);
        do_enter();
        check_st("t2_miss2", 2'd0, 1'b0, 1'b0, 2'd2);
        send_bits(16'hA4, 8);
        do_enter();
        check_st("t2_alarm", 2'd3, 1'b0, 1'b1, 2'd3);
`ifdef ALARM_TIMER_EN
        repeat (3) cyc();
        clear_alarm = 1'b1;
        cyc();
        clear_alarm = 1'b0;
        check_st("t4_early_clear", 2'd3, 1'b0, 1'b1, 2'd3);
`endif
        send_bits(16'hA5, 8);
        do_enter();
        check_st("t2_ignore", 2'd3, 1'b0, 1'b1, 2'd3);
`ifdef ALARM_TIMER_EN
        // 13 edges spent in ALARM so far; exit on the 17th edge (timer==16 sampled)
        hold_clear("t4_exit_edges", 4);
`else
        clear_alarm = 1'b1;
        cyc();
        clear_alarm = 1'b0;
`endif
        check_st("t4_exit", 2'd0, 1'b0, 1'b0, 2'd0);

        // Short code misses; over-long code matches with the 9th bit discarded
        send_bits(16'h52, 7);
        do_enter();
        check_st("t3_short", 2'd0, 1'b0, 1'b0, 2'd1);
        send_bits(16'h14A, 9);
        do_enter();
        check_st("t3_long", 2'd2, 1'b1, 1'b0, 2'd0);
        do_enter();
        check_st("t3_relock", 2'd0, 1'b0, 1'b0, 2'd0);

        // Last bit arriving together with enter is dropped
        send_bits(16'h52, 7);
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        enter     = 1'b1;
        cyc();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        enter     = 1'b0;
        check_st("t5_same_cycle", 2'd0, 1'b0, 1'b0, 2'd1);
        send_bits(16'hA5, 8);
        do_enter();
        check_st("t5_clean", 2'd2, 1'b1, 1'b0, 2'd0);
        do_enter();

        // Bare enters are misses; clear_alarm on the first ALARM cycle
        do_enter();
        check_st("t6_bare1", 2'd0, 1'b0, 1'b0, 2'd1);
        do_enter();
        check_st("t6_bare2", 2'd0, 1'b0, 1'b0, 2'd2);
        do_enter();
        check_st("t6_bare_alarm", 2'd3, 1'b0, 1'b1, 2'd3);
        clear_alarm = 1'b1;
        cyc();
`ifdef ALARM_TIMER_EN
        check_st("t6_clear_c1", 2'd3, 1'b0, 1'b1, 2'd3);
        hold_clear("t6_exit_edges", 16);
`else
        clear_alarm = 1'b0;
        check_st("t6_clear_c1", 2'd0, 1'b0, 1'b0, 2'd0);
`endif
        check_st("t6_exit", 2'd0, 1'b0, 1'b0, 2'd0);

        // Asynchronous reset mid-COLLECT and in UNLOCK
        do_enter();
        send_bits(16'hA, 4);
        check_st("t7_pre", 2'd1, 1'b0, 1'b0, 2'd1);
        #2 reset_L = 1'b0;
        #1 check_st("t7_async_collect", 2'd0, 1'b0, 1'b0, 2'd0);
        cyc();
        reset_L = 1'b1;
        check_st("t7_release", 2'd0, 1'b0, 1'b0, 2'd0);
        send_bits(16'hA5, 8);
        do_enter();
        check_st("t7_unlock", 2'd2, 1'b1, 1'b0, 2'd0);
        #2 reset_L = 1'b0;
        #1 check_st("t7_async_unlock", 2'd0, 1'b0, 1'b0, 2'd0);
        cyc();
        reset_L = 1'b1;
        cyc();
        check_st("t7_idle", 2'd0, 1'b0, 1'b0, 2'd0);
        send_bits(16'hA5, 8);
        do_enter();
        check_st("t7_reunlock", 2'd2, 1'b1, 1'b0, 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
